calc_display: RTL and testbench

//   Reader side of the calculator's 16-bit result output. Captures the accumulator value on a load strobe
//   and shows it as 4 hex digits on the board's multiplexed, active-low 7-segment display.

---
 rtl/calc_display.sv | 103 ++++++++++
 tb/tb_calc_display.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/calc_display.sv
// Multiplexed 4-digit hex display for the calculator result bus.
// Shadow-captures value on load and scans one active-low digit per refresh slot.
module calc_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PTOP = PW'(REFRESH_DIV - 1);

  logic [15:0]   shadow;
  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          lz;
  logic          blank;
  logic [6:0]    hex;

  assign dp = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (enable) begin
      if (pre == PTOP) begin
        pre <= '0;
        idx <= idx + 2'd1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  always_comb begin
    nib = shadow[4*idx +: 4];
  end

  // digit 0 is never a leading zero
  always_comb begin
    lz = 1'b0;
    unique case (idx)
      2'd0: lz = 1'b0;
      2'd1: lz = (shadow[15:4] == 12'h000);
      2'd2: lz = (shadow[15:8] == 8'h00);
      2'd3: lz = (shadow[15:12] == 4'h0);
    endcase
    blank = BLANK_LZ && lz;
  end

  always_comb begin
    hex = 7'h7F;
    unique case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else if (!enable || blank) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= hex;
    end
  end

endmodule

// File: tb/tb_calc_display.sv
// Randomized bench for calc_display against a cycle-level reference model.
// Runs a blanking and a non-blanking instance side by side on shared inputs.
module tb_calc_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;

  int checks = 0;
  int errors = 0;

  int m_sh = 0;
  int m_pre = 0;
  int m_idx = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                           7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  calc_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .enable(enable), .an(an), .seg(seg), .dp(dp)
  );

  calc_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .enable(enable), .an(an2), .seg(seg2), .dp(dp2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dark();
    check("an_dark", an, 4'hF);
    check("seg_dark", seg, 7'h7F);
    check("an2_dark", an2, 4'hF);
    check("seg2_dark", seg2, 7'h7F);
    check("dp", dp, 1);
  endtask

  // One clock: predict outputs from pre-edge model state, then advance it.
  task automatic step();
    int e_an, e_seg, e_an2, e_seg2, nb;
    bit bl;
    e_an = 4'hF; e_seg = 7'h7F;
    e_an2 = 4'hF; e_seg2 = 7'h7F;
    if (rst_n && enable) begin
      nb = (m_sh >> (4 * m_idx)) & 15;
      e_an2 = 15 & ~(1 << m_idx);
      e_seg2 = tbl[nb];
      bl = (m_idx != 0) && ((m_sh >> (4 * m_idx)) == 0);
      e_an = bl ? 4'hF : e_an2;
      e_seg = bl ? 7'h7F : e_seg2;
    end
    if (!rst_n) begin
      m_sh = 0; m_pre = 0; m_idx = 0;
    end else begin
      if (load) m_sh = value;
      if (enable) begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          m_idx = (m_idx + 1) % 4;
        end else begin
          m_pre++;
        end
      end
    end
    @(posedge clk);
    #1;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("an_nolz", an2, e_an2);
    check("seg_nolz", seg2, e_seg2);
    check("dp", dp, 1);
    check("dp_nolz", dp2, 1);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int nz;
    #12;
    check_dark();
    rst_n = 1'b1;
    enable = 1'b1;
    step();
    repeat (5) step();

    do_load(16'h1A3F);
    repeat (18) step();

    do_load(16'h0005);
    repeat (16) step();

    // land a load in the middle of slot 2
    while (!(m_idx == 2 && m_pre == 1)) step();
    do_load(16'hFFFF);
    repeat (8) step();

    while (!(m_idx == 1 && m_pre == 1)) step();
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    repeat (8) step();

    // async reset between edges during slot 3
    while (m_idx != 3) step();
    #3;
    rst_n = 1'b0;
    #1;
    check_dark();
    m_sh = 0; m_pre = 0; m_idx = 0;
    step();
    #2;
    rst_n = 1'b1;
    repeat (6) step();

    repeat (600) begin
      enable = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 3) == 0);
      nz = $urandom_range(0, 4);
      value = 16'($urandom) & 16'((32'h1 << (4 * nz)) - 1);
      step();
    end
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
